// File: rtl/fft_in_pingpong_if.sv
// Bus bundle for the ping-pong sample store: write side from the bit-reverse
// resort stage and read/control side toward the butterfly engine.
interface fft_in_pingpong_if #(
  parameter int DW = 16,
  parameter int AW = 9
);
  logic signed [DW-1:0] wr_re;
  logic signed [DW-1:0] wr_im;
  logic [AW-1:0]        wr_addr;
  logic                 wr_en;
  logic                 resort_complete;
  logic [9:0]           N;
  logic                 eng_rd_en;
  logic [AW-1:0]        eng_rd_addr;
  logic                 eng_done;
  logic signed [DW-1:0] eng_rd_re;
  logic signed [DW-1:0] eng_rd_im;
  logic                 eng_rd_valid;
  logic                 frame_ready;
  logic [9:0]           frame_len;
  logic                 frame_drop;

  modport master (
    output wr_re, wr_im, wr_addr, wr_en, resort_complete, N,
    output eng_rd_en, eng_rd_addr, eng_done,
    input  eng_rd_re, eng_rd_im, eng_rd_valid, frame_ready, frame_len, frame_drop
  );

  modport slave (
    input  wr_re, wr_im, wr_addr, wr_en, resort_complete, N,
    input  eng_rd_en, eng_rd_addr, eng_done,
    output eng_rd_re, eng_rd_im, eng_rd_valid, frame_ready, frame_len, frame_drop
  );
endinterface

// File: rtl/fft_in_pingpong.sv
// Two-bank FFT input store: the resort stage fills one bank while the engine
// reads the other; banks swap on frame completion. DW/AW must match the bus.
module fft_in_pingpong #(
  parameter int DW = 16,
  parameter int AW = 9
) (
  input logic              clk,
  input logic              rst_n,
  fft_in_pingpong_if.slave bus
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_ENGINE} bank_state_t;

  logic [2*DW-1:0] mem [2][DEPTH];

  bank_state_t     bank_q [2];
  bank_state_t     bank_d [2];
  logic [9:0]      len_q [2];
  logic [9:0]      len_d [2];
  logic            fill_ptr_q, fill_ptr_d;
  logic            eng_ptr_q, eng_ptr_d;
  logic            stall_q, stall_d;
  logic            frame_ready_q, frame_ready_d;
  logic [9:0]      frame_len_q, frame_len_d;
  logic            frame_drop_q, frame_drop_d;
  logic            rd_valid_q, rd_valid_d;
  logic [2*DW-1:0] rd_data_q, rd_data_d;

  logic            do_wr;
  logic            wr_bank;
  logic            free_now;
  logic [9:0]      n_norm;

  // Unsupported frame lengths fall back to the full 512-point frame.
  always_comb begin
    case (bus.N)
      10'd64, 10'd128, 10'd256: n_norm = bus.N;
      default:                  n_norm = 10'd512;
    endcase
  end

  // Bank bookkeeping: fill side (write, complete, stall/drop) then engine side.
  always_comb begin
    bank_d        = bank_q;
    len_d         = len_q;
    fill_ptr_d    = fill_ptr_q;
    eng_ptr_d     = eng_ptr_q;
    stall_d       = stall_q;
    frame_ready_d = frame_ready_q;
    frame_len_d   = frame_len_q;
    frame_drop_d  = 1'b0;
    wr_bank       = fill_ptr_q;
    do_wr         = 1'b0;
    free_now      = bus.eng_done && frame_ready_q;

    // While stalled, the fill pointer sits on a FULL bank; the first write seen
    // after the other bank drains moves the pointer there and ends the stall.
    if (bus.wr_en == 1'b1) begin
      if (!stall_q) begin
        do_wr = 1'b1;
      end else if (bank_q[!fill_ptr_q] == B_EMPTY) begin
        do_wr      = 1'b1;
        wr_bank    = !fill_ptr_q;
        fill_ptr_d = !fill_ptr_q;
        stall_d    = 1'b0;
      end
    end

    if (do_wr && bank_q[wr_bank] == B_EMPTY) begin
      bank_d[wr_bank] = B_FILLING;
      len_d[wr_bank]  = n_norm;
    end

    // The final write may share the cycle with resort_complete, so do_wr also
    // qualifies the completion. A bank freed by eng_done this cycle is free.
    if (bus.resort_complete) begin
      if (stall_d) begin
        frame_drop_d = 1'b1;
      end else if (bank_q[wr_bank] == B_FILLING || do_wr) begin
        bank_d[wr_bank] = B_FULL;
        if (bank_q[!wr_bank] == B_EMPTY || (free_now && eng_ptr_q == !wr_bank))
          fill_ptr_d = !wr_bank;
        else
          stall_d = 1'b1;
      end
    end

    // Looking at bank_d lets a frame completing on the engine bank raise
    // frame_ready on the very next cycle.
    if (free_now) begin
      bank_d[eng_ptr_q] = B_EMPTY;
      eng_ptr_d         = !eng_ptr_q;
      frame_ready_d     = 1'b0;
    end else if (!frame_ready_q && bank_d[eng_ptr_q] == B_FULL) begin
      bank_d[eng_ptr_q] = B_ENGINE;
      frame_ready_d     = 1'b1;
      frame_len_d       = len_d[eng_ptr_q];
    end
  end

  // Engine read port: one-cycle latency, always from the engine-pointer bank.
  always_comb begin
    rd_valid_d = bus.eng_rd_en;
    rd_data_d  = rd_data_q;
    if (bus.eng_rd_en)
      rd_data_d = mem[eng_ptr_q][bus.eng_rd_addr];
  end

  // Sample RAM; contents are not reset.
  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_bank][bus.wr_addr] <= {bus.wr_re, bus.wr_im};
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0]     <= B_EMPTY;
      bank_q[1]     <= B_EMPTY;
      len_q[0]      <= '0;
      len_q[1]      <= '0;
      fill_ptr_q    <= 1'b0;
      eng_ptr_q     <= 1'b0;
      stall_q       <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_len_q   <= '0;
      frame_drop_q  <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      bank_q        <= bank_d;
      len_q         <= len_d;
      fill_ptr_q    <= fill_ptr_d;
      eng_ptr_q     <= eng_ptr_d;
      stall_q       <= stall_d;
      frame_ready_q <= frame_ready_d;
      frame_len_q   <= frame_len_d;
      frame_drop_q  <= frame_drop_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign bus.eng_rd_re    = rd_data_q[2*DW-1:DW];
  assign bus.eng_rd_im    = rd_data_q[DW-1:0];
  assign bus.eng_rd_valid = rd_valid_q;
  assign bus.frame_ready  = frame_ready_q;
  assign bus.frame_len    = frame_len_q;
  assign bus.frame_drop   = frame_drop_q;
endmodule

// File: tb/tb_fft_in_pingpong.sv
// Scoreboard bench for fft_in_pingpong: the reference model is a queue of
// accepted frames (head = frame the engine reads); read expectations are
// queued on issue and popped by an independent monitor.
module tb_fft_in_pingpong;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_in_pingpong_if #(.DW(16), .AW(9)) bus ();

  fft_in_pingpong #(.DW(16), .AW(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          kind;
    int unsigned seed;
    int          len;
  } frame_t;

  typedef struct {
    bit          care;
    logic [31:0] data;
  } rd_exp_t;

  frame_t  q[$];
  rd_exp_t exp_q[$];
  int      checks = 0;
  int      errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int norm_len(input int n);
    if (n == 64 || n == 128 || n == 256) return n;
    return 512;
  endfunction

  function automatic logic [8:0] bitrev(input int v, input int lg);
    logic [8:0] r;
    r = '0;
    for (int b = 0; b < lg; b++) r[lg-1-b] = v[b];
    return r;
  endfunction

  // Sample value the resort stage produces for an address of a given frame.
  function automatic logic [31:0] sample(input frame_t f, input int a);
    logic [15:0] re, im;
    if (f.kind == 0) begin
      re = 16'(a);
      im = 16'(-a);
    end else begin
      re = 16'(f.seed ^ 32'(a * 40503));
      im = 16'((f.seed >> 16) + 32'(a * 7919));
    end
    return {re, im};
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.frame_ready), 0);
    chk({tag, "_len"},   32'(bus.frame_len), 0);
    chk({tag, "_drop"},  32'(bus.frame_drop), 0);
    chk({tag, "_valid"}, 32'(bus.eng_rd_valid), 0);
    chk({tag, "_rd"},    {bus.eng_rd_re, bus.eng_rd_im}, 0);
  endtask

  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.resort_complete = 1'b0; bus.eng_done = 1'b0;
    bus.eng_rd_en = 1'b0;
  endtask

  // Write one frame at bit-reversed addresses. done_at = write index carrying
  // an eng_done pulse (-1: none). gaps inserts idle cycles with junk bus data.
  task automatic write_frame(input int n_raw, input int kind, input int unsigned seed,
                             input int done_at, input bit gaps);
    frame_t      f;
    int          len, lg;
    bit          accept;
    logic [8:0]  a;
    logic [31:0] d;
    len = norm_len(n_raw);
    lg = $clog2(len);
    accept = (q.size() < 2);
    f.kind = kind; f.seed = seed; f.len = len;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      a = bitrev(i, lg);
      d = sample(f, int'(a));
      bus.wr_en = 1'b1; bus.wr_addr = a; bus.N = n_raw[9:0];
      bus.wr_re = d[31:16]; bus.wr_im = d[15:0];
      bus.resort_complete = (i == len - 1);
      bus.eng_done = (i == done_at);
      if (i == done_at && q.size() > 0) void'(q.pop_front());
      if (gaps && i != len - 1 && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        bus.wr_en = 1'b0; bus.resort_complete = 1'b0; bus.eng_done = 1'b0;
        bus.wr_addr = 9'($urandom); bus.wr_re = 16'($urandom); bus.wr_im = 16'($urandom);
      end
    end
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.resort_complete = 1'b0; bus.eng_done = 1'b0;
    chk("frame_drop", 32'(bus.frame_drop), 32'(!accept));
    if (accept) q.push_back(f);
    if (done_at == len - 1) begin
      chk("ready_gap", 32'(bus.frame_ready), 0);
      @(posedge clk); #1;
    end
    chk("frame_ready", 32'(bus.frame_ready), 32'(q.size() > 0));
    if (q.size() > 0) chk("frame_len", 32'(bus.frame_len), 32'(q[0].len));
    @(posedge clk); #1;
    chk("drop_pulse_end", 32'(bus.frame_drop), 0);
  endtask

  // Issue reads against the engine frame; all=1 reads 0..cnt-1 in order.
  task automatic read_frame(input int cnt, input bit all);
    int      a;
    rd_exp_t e;
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk); #1;
      a = all ? i : $urandom_range(0, q[0].len - 1);
      bus.eng_rd_en = 1'b1; bus.eng_rd_addr = 9'(a);
      e.care = 1'b1; e.data = sample(q[0], a);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.eng_rd_en = 1'b0; bus.eng_rd_addr = 9'($urandom);
  endtask

  task automatic eng_done_pulse();
    @(posedge clk); #1; bus.eng_done = 1'b1;
    @(posedge clk); #1; bus.eng_done = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    chk("ready_after_done", 32'(bus.frame_ready), 0);
    @(posedge clk); #1;
    chk("ready_reassert", 32'(bus.frame_ready), 32'(q.size() > 0));
    if (q.size() > 0) chk("len_reassert", 32'(bus.frame_len), 32'(q[0].len));
  endtask

  // Monitor: every valid read beat must match the oldest queued expectation.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (bus.eng_rd_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: valid=1 with no read issued at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          if (e.care && {bus.eng_rd_re, bus.eng_rd_im} !== e.data) begin
            errors++;
            $display("FAIL rd_data: got %0h expected %0h at %0t",
                     {bus.eng_rd_re, bus.eng_rd_im}, e.data, $time);
          end
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int      nsel, len, done_at;
    int      nlist [6];
    rd_exp_t e;
    nlist = '{64, 128, 256, 512, 100, 0};
    idle_inputs();
    bus.wr_addr = '0; bus.wr_re = '0; bus.wr_im = '0; bus.N = 10'd64; bus.eng_rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 1) N=64 ramp frame, full readback.
    write_frame(64, 0, 0, -1, 1'b0);
    read_frame(64, 1'b1);

    // 2) 512-point frame with eng_done mid-frame: swap without drop.
    write_frame(512, 1, $urandom, 100, 1'b0);
    read_frame(512, 1'b1);

    // 4+5) Completion coincides with eng_done; idle cycles carry junk bus data.
    write_frame(256, 1, $urandom, 255, 1'b1);
    read_frame(256, 1'b1);

    // 3) Two more frames without eng_done: the second is dropped.
    write_frame(128, 1, $urandom, -1, 1'b1);
    write_frame(512, 1, $urandom, -1, 1'b0);
    read_frame(64, 1'b0);
    eng_done_pulse();
    read_frame(128, 1'b1);
    eng_done_pulse();
    // Reads with no frame ready still produce a valid beat.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.eng_rd_en = 1'b1; bus.eng_rd_addr = 9'($urandom);
      e.care = 1'b0; e.data = '0;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.eng_rd_en = 1'b0;

    // 6) Reset in the middle of a 128-point frame.
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      bus.wr_en = 1'b1; bus.N = 10'd128; bus.wr_addr = bitrev(i, 7);
      bus.wr_re = 16'($urandom); bus.wr_im = 16'($urandom);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check_reset_outputs("midreset");
    q.delete();
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    write_frame(128, 1, $urandom, -1, 1'b0);
    read_frame(128, 1'b1);
    eng_done_pulse();

    // Randomized frames: lengths (incl. unsupported), done placement, gaps.
    for (int f = 0; f < 8; f++) begin
      nsel = nlist[$urandom_range(0, 5)];
      len = norm_len(nsel);
      done_at = -1;
      if (q.size() == 1) begin
        case ($urandom_range(0, 2))
          1: done_at = len - 1;
          2: done_at = $urandom_range(1, len - 2);
          default: done_at = -1;
        endcase
      end
      write_frame(nsel, 1, $urandom, done_at, 1'($urandom_range(0, 1)));
      if (q.size() > 0) read_frame(16, 1'b0);
      if (q.size() > 0 && $urandom_range(0, 2) == 0) eng_done_pulse();
    end
    while (q.size() > 0) begin
      read_frame(16, 1'b0);
      eng_done_pulse();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
